// File: rtl/bldc_hall_if.sv
// Hall-sensor bus between a generator (master drives the hall side) and its consumer.
// Carries control inputs to the generator and the hall code, step pulse and position back out.
interface bldc_hall_if #(
   parameter int PERIOD_WIDTH  = 16,
   parameter int COUNTER_WIDTH = 8
);
   logic                     enable;
   logic                     dir;
   logic [PERIOD_WIDTH-1:0]  period;
   logic                     period_load;
   logic                     step_req;
   logic [2:0]               hall;
   logic                     step;
   logic [COUNTER_WIDTH-1:0] position;
   logic                     load_pending;

   modport master (
      input  enable, dir, period, period_load, step_req,
      output hall, step, position, load_pending
   );

   modport slave (
      output enable, dir, period, period_load, step_req,
      input  hall, step, position, load_pending
   );
endinterface

// File: rtl/bldc_hall_generator.sv
// Six-step BLDC hall sequence generator with programmable step period, direction,
// manual stepping and boundary-synchronised period reload.
module bldc_hall_generator #(
   parameter int PERIOD_WIDTH  = 16,
   parameter int COUNTER_WIDTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   bldc_hall_if.master bus
);
   // State encoding is the hall code itself, so hall comes straight off the flops.
   typedef enum logic [2:0] {
      S1 = 3'b101, S2 = 3'b100, S3 = 3'b110,
      S4 = 3'b010, S5 = 3'b011, S6 = 3'b001
   } state_t;

   localparam logic [PERIOD_WIDTH-1:0]  P_ONE = PERIOD_WIDTH'(1);
   localparam logic [COUNTER_WIDTH-1:0] C_ONE = COUNTER_WIDTH'(1);

   state_t                   state, state_next;
   logic [PERIOD_WIDTH-1:0]  active, pending, timer;
   logic [COUNTER_WIDTH-1:0] position;
   logic                     step, load_pending;
   logic                     at_end, run_adv, man_adv, advance, stalled;

   assign stalled = (active == '0);
   assign at_end  = !stalled && (timer == active - P_ONE);
   assign run_adv = bus.enable && at_end;
   assign man_adv = !bus.enable && bus.step_req;
   assign advance = run_adv || man_adv;

   always_ff @(posedge clk) begin
      if (reset) state <= S1;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (advance) begin
         case (state)
            S1:      state_next = bus.dir ? S2 : S6;
            S2:      state_next = bus.dir ? S3 : S1;
            S3:      state_next = bus.dir ? S4 : S2;
            S4:      state_next = bus.dir ? S5 : S3;
            S5:      state_next = bus.dir ? S6 : S4;
            S6:      state_next = bus.dir ? S1 : S5;
            default: state_next = S1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active       <= '0;
         pending      <= '0;
         timer        <= '0;
         position     <= '0;
         step         <= 1'b0;
         load_pending <= 1'b0;
      end else begin
         step <= advance;
         if (advance)
            position <= bus.dir ? position + C_ONE : position - C_ONE;

         if (advance || (bus.period_load && stalled))
            timer <= '0;
         else if (bus.enable && !stalled)
            timer <= timer + P_ONE;

         // A load coinciding with an advance, or arriving while stalled, takes effect at once;
         // otherwise it waits for the next step boundary, and the consuming advance uses the old period.
         if (bus.period_load) begin
            if (advance || stalled) begin
               active       <= bus.period;
               load_pending <= 1'b0;
            end else begin
               pending      <= bus.period;
               load_pending <= 1'b1;
            end
         end else if (advance && load_pending) begin
            active       <= pending;
            load_pending <= 1'b0;
         end
      end
   end

   assign bus.hall         = state;
   assign bus.step         = step;
   assign bus.position     = position;
   assign bus.load_pending = load_pending;
endmodule

// File: tb/tb_bldc_hall_generator.sv
// Randomised and directed checks of bldc_hall_generator against a cycles-remaining reference model
// and a hall-counter decoder watching the hall output.
module tb_bldc_hall_generator;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   bldc_hall_if #(.PERIOD_WIDTH(16), .COUNTER_WIDTH(8)) bus ();

   bldc_hall_generator #(.PERIOD_WIDTH(16), .COUNTER_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   logic [2:0] seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

   // Model: sequence index, position, active period, pending period and cycles left in the interval.
   int m_idx = 0, m_pos = 0, m_active = 0, m_pend = 0, m_rem = 0;
   bit m_lp = 0, m_step = 0;

   task automatic tick();
      bit adv, sl;
      @(posedge clk);
      if (reset) begin
         m_idx = 0; m_pos = 0; m_active = 0; m_pend = 0; m_rem = 0; m_lp = 0; m_step = 0;
      end else begin
         adv = (bus.enable && m_active != 0 && m_rem == 1) || (!bus.enable && bus.step_req);
         sl  = bus.period_load && m_active == 0 && !adv;
         m_step = adv;
         if (adv) begin
            m_idx = bus.dir ? (m_idx + 1) % 6 : (m_idx + 5) % 6;
            m_pos = bus.dir ? (m_pos + 1) % 256 : (m_pos + 255) % 256;
         end
         if (bus.period_load && (adv || m_active == 0)) begin
            m_active = int'(bus.period); m_lp = 0;
         end else if (bus.period_load) begin
            m_pend = int'(bus.period); m_lp = 1;
         end else if (adv && m_lp) begin
            m_active = m_pend; m_lp = 0;
         end
         if (adv || sl) m_rem = m_active;
         else if (bus.enable && m_active != 0) m_rem = m_rem - 1;
      end
      #1;
   endtask

   task automatic do_reset();
      bus.enable = 0; bus.dir = 1; bus.period = '0; bus.period_load = 0; bus.step_req = 0;
      reset = 1; tick(); reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk += 4;
      if (bus.hall !== 3'b101) begin n_fail++; $display("FAIL reset_hall: got %b expected 101", bus.hall); end
      if (bus.step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b expected 0", bus.step); end
      if (bus.position !== 8'h00) begin n_fail++; $display("FAIL reset_pos: got %h expected 00", bus.position); end
      if (bus.load_pending !== 1'b0) begin n_fail++; $display("FAIL reset_lp: got %b expected 0", bus.load_pending); end
   endtask

   task automatic test_forward_period4();
      do_reset();
      bus.period = 16'd4; bus.period_load = 1; bus.enable = 1; bus.dir = 1;
      tick();
      bus.period_load = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         n_chk += 2;
         if (bus.step !== ((k % 4) == 0)) begin n_fail++; $display("FAIL fwd4_step k=%0d: got %b expected %b", k, bus.step, (k % 4) == 0); end
         if (bus.hall !== seq[k / 4]) begin n_fail++; $display("FAIL fwd4_hall k=%0d: got %b expected %b", k, bus.hall, seq[k / 4]); end
      end
   endtask

   task automatic test_reverse_period1();
      logic [2:0] exp_h [7] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
      do_reset();
      bus.period = 16'd1; bus.period_load = 1; bus.enable = 1; bus.dir = 0;
      tick();
      bus.period_load = 0;
      for (int k = 0; k < 7; k++) begin
         tick();
         n_chk += 2;
         if (bus.hall !== exp_h[k]) begin n_fail++; $display("FAIL rev1_hall k=%0d: got %b expected %b", k, bus.hall, exp_h[k]); end
         if (bus.step !== 1'b1) begin n_fail++; $display("FAIL rev1_step k=%0d: got %b expected 1", k, bus.step); end
      end
      n_chk++;
      if (bus.position !== 8'hF9) begin n_fail++; $display("FAIL rev1_pos: got %h expected f9", bus.position); end
   endtask

   task automatic test_pending_load();
      do_reset();
      bus.period = 16'd10; bus.period_load = 1; bus.enable = 1; bus.dir = 1;
      tick();
      bus.period_load = 0;
      tick(); tick();
      bus.period = 16'd3; bus.period_load = 1;
      tick();
      bus.period_load = 0;
      n_chk++;
      if (bus.load_pending !== 1'b1) begin n_fail++; $display("FAIL pend_set: got %b expected 1", bus.load_pending); end
      // load edge was tick 0; steps expected at ticks 10, 13, 16, 19
      for (int k = 4; k <= 20; k++) begin
         tick();
         n_chk += 2;
         if (bus.step !== (k == 10 || k == 13 || k == 16 || k == 19)) begin
            n_fail++; $display("FAIL pend_step k=%0d: got %b", k, bus.step);
         end
         if (bus.load_pending !== (k < 10)) begin n_fail++; $display("FAIL pend_lp k=%0d: got %b expected %b", k, bus.load_pending, k < 10); end
      end
   endtask

   task automatic test_manual();
      do_reset();
      bus.period = 16'd50; bus.period_load = 1;
      tick();
      bus.period_load = 0; bus.step_req = 1; bus.dir = 1;
      tick(); tick(); tick();
      bus.dir = 0;
      tick();
      n_chk += 3;
      if (bus.hall !== 3'b110) begin n_fail++; $display("FAIL man_hall: got %b expected 110", bus.hall); end
      if (bus.position !== 8'd2) begin n_fail++; $display("FAIL man_pos: got %h expected 02", bus.position); end
      if (bus.step !== 1'b1) begin n_fail++; $display("FAIL man_step: got %b expected 1", bus.step); end
      bus.enable = 1;
      tick();
      bus.step_req = 0;
      n_chk += 2;
      if (bus.step !== 1'b0) begin n_fail++; $display("FAIL man_ignored_step: got %b expected 0", bus.step); end
      if (bus.hall !== 3'b110) begin n_fail++; $display("FAIL man_ignored_hall: got %b expected 110", bus.hall); end
   endtask

   task automatic test_wrap();
      do_reset();
      bus.step_req = 1; bus.dir = 0;
      tick();
      n_chk += 2;
      if (bus.position !== 8'hFF) begin n_fail++; $display("FAIL wrap_dn: got %h expected ff", bus.position); end
      if (bus.hall !== 3'b001) begin n_fail++; $display("FAIL wrap_dn_hall: got %b expected 001", bus.hall); end
      bus.dir = 1;
      tick();
      bus.step_req = 0;
      n_chk += 2;
      if (bus.position !== 8'h00) begin n_fail++; $display("FAIL wrap_up: got %h expected 00", bus.position); end
      if (bus.hall !== 3'b101) begin n_fail++; $display("FAIL wrap_up_hall: got %b expected 101", bus.hall); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.period = 16'd10; bus.period_load = 1; bus.enable = 1;
      tick();
      bus.period_load = 0;
      tick(); tick(); tick();
      bus.period = 16'd5; bus.period_load = 1;
      tick();
      bus.period_load = 0;
      n_chk++;
      if (bus.load_pending !== 1'b1) begin n_fail++; $display("FAIL rmid_pend: got %b expected 1", bus.load_pending); end
      reset = 1;
      tick();
      reset = 0;
      n_chk += 3;
      if (bus.hall !== 3'b101) begin n_fail++; $display("FAIL rmid_hall: got %b expected 101", bus.hall); end
      if (bus.position !== 8'h00) begin n_fail++; $display("FAIL rmid_pos: got %h expected 00", bus.position); end
      if (bus.load_pending !== 1'b0) begin n_fail++; $display("FAIL rmid_lp: got %b expected 0", bus.load_pending); end
      for (int k = 0; k < 25; k++) begin
         tick();
         n_chk++;
         if (bus.step !== 1'b0) begin n_fail++; $display("FAIL rmid_stalled k=%0d: got %b expected 0", k, bus.step); end
      end
   endtask

   task automatic test_random();
      int hc, prev_i, cur_i;
      do_reset();
      hc = 0; prev_i = 0;
      for (int k = 0; k < 600; k++) begin
         bus.period_load = ($urandom_range(0, 7) == 0);
         bus.period      = 16'($urandom_range(0, 6));
         if ($urandom_range(0, 15) == 0) bus.enable = ~bus.enable;
         if ($urandom_range(0, 9) == 0) bus.dir = ~bus.dir;
         bus.step_req    = ($urandom_range(0, 3) == 0);
         tick();
         // independent hall-counter decode of the observed code stream
         cur_i = -1;
         for (int j = 0; j < 6; j++) if (bus.hall === seq[j]) cur_i = j;
         n_chk += 5;
         if (cur_i < 0) begin
            n_fail++; $display("FAIL rnd_illegal k=%0d: got %b", k, bus.hall);
         end else begin
            if ((cur_i - prev_i + 6) % 6 == 1) hc = (hc + 1) % 256;
            else if ((cur_i - prev_i + 6) % 6 == 5) hc = (hc + 255) % 256;
            prev_i = cur_i;
         end
         if (bus.hall !== seq[m_idx]) begin n_fail++; $display("FAIL rnd_hall k=%0d: got %b expected %b", k, bus.hall, seq[m_idx]); end
         if (bus.step !== m_step) begin n_fail++; $display("FAIL rnd_step k=%0d: got %b expected %b", k, bus.step, m_step); end
         if (bus.position !== 8'(m_pos) || bus.position !== 8'(hc)) begin
            n_fail++; $display("FAIL rnd_pos k=%0d: got %h expected %h counter %h", k, bus.position, 8'(m_pos), 8'(hc));
         end
         if (bus.load_pending !== m_lp) begin n_fail++; $display("FAIL rnd_lp k=%0d: got %b expected %b", k, bus.load_pending, m_lp); end
      end
   endtask

   initial begin
      test_reset();
      test_forward_period4();
      test_reverse_period1();
      test_pending_load();
      test_manual();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
